// File: rtl/chunked_negator_if.sv
// Handshake bundle for chunked_negator: operand side (in_*) and result side (out_*).
// The unit is the slave; the producer/consumer environment is the master.
interface chunked_negator_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [1:0]   in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_cout;
    logic         out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_cout, out_ovf
    );
endinterface

// File: rtl/chunked_negator.sv
// Multi-cycle two's-complement unit: pass / negate / abs / sign-magnitude, W bits per clock.
// Define CHUNKED_NEGATOR_SAT_EN to saturate the most-negative overflow case to 0111...1.
module chunked_negator #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic            clk,
    input  logic            rst,
    chunked_negator_if.slave bus
);

    localparam int CHUNKS = N / W;
    localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);
    localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]  SAT_POS  = {1'b0, {(N-1){1'b1}}};

`ifdef CHUNKED_NEGATOR_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One chunk of (op ^ {W{inv}}) + cin; bit W is the carry out.
    function automatic logic [W:0] chunk_add(input logic [W-1:0] chunk,
                                             input logic         inv,
                                             input logic         cin);
        return {1'b0, chunk ^ {W{inv}}} + {{W{1'b0}}, cin};
    endfunction

    function automatic logic [N-1:0] saturate(input logic [N-1:0] v, input logic ovf);
        if (SAT_EN && ovf) return SAT_POS;
        return v;
    endfunction

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  carry_q, carry_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic signed [N-1:0]   res_q, res_d;
    logic                  cout_q, cout_d;
    logic                  ovf_q, ovf_d;
    logic signed [N-1:0]   op_q, op_d;
    logic                  neg_q, neg_d;

    logic                  accept;
    logic [W-1:0]          op_chunk;
    logic [W:0]            sum;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = res_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        carry_d    = carry_q;
        ovf_pend_d = ovf_pend_q;
        res_d      = res_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        op_d       = op_q;
        neg_d      = neg_q;
        op_chunk   = op_q[int'(k_q) * W +: W];
        sum        = chunk_add(op_chunk, neg_q, carry_q);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_mode == 2'b11) begin
                        op_d = {1'b0, bus.in_data[N-2:0]};
                    end else begin
                        op_d = bus.in_data;
                    end
                    case (bus.in_mode)
                        2'b00:   neg_d = 1'b0;
                        2'b01:   neg_d = 1'b1;
                        default: neg_d = bus.in_data[N-1];
                    endcase
                    // Only negate/abs of the most-negative value is unrepresentable;
                    // sign-magnitude drops the sign bit first and cannot overflow.
                    ovf_pend_d = ((bus.in_mode == 2'b01) || (bus.in_mode == 2'b10)) &&
                                 (bus.in_data == MOST_NEG);
                    carry_d = neg_d;
                    k_d     = '0;
                    res_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end

            RUN: begin
                res_d[int'(k_q) * W +: W] = sum[W-1:0];
                carry_d = sum[W];
                if (k_q == K_LAST) begin
                    // Final chunk: flags latch and saturation folds in on the same edge.
                    res_d   = saturate(res_d, ovf_pend_q);
                    cout_d  = (SAT_EN && ovf_pend_q) ? 1'b0 : sum[W];
                    ovf_d   = ovf_pend_q;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            carry_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            res_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            carry_q    <= carry_d;
            ovf_pend_q <= ovf_pend_d;
            res_q      <= res_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    // Operand and negate flag are only consumed in RUN, which always follows an accept.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        neg_q <= neg_d;
    end

endmodule

// File: doc/chunked_negator.md
# chunked_negator

Multi-cycle, parametrised two's-complement unit that converts an N-bit operand W bits per clock through a single registered ripple carry. It supports pass-through, negate, absolute value and sign-magnitude-to-two's-complement modes. Valid/ready handshakes sit on both sides. It sits ahead of the half-precision adder's mantissa alignment and subtraction path, where it trades latency for a short carry chain.

## Interface
- `N`, 16, operand width in bits; must be at least 2.
- `W`, 4, chunk width processed per cycle; N must be a multiple of W; W = N is legal.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  operand offered.
- `in_ready`  output  1  unit can accept an operand.
- `in_data`  input  N  operand.
- `in_mode`  input  2  mode: 00 pass, 01 negate, 10 abs, 11 sign-magnitude to two's complement.
- `out_valid`  output  1  result held.
- `out_ready`  input  1  consumer takes the result.
- `out_data`  output  N  result.
- `out_cout`  output  1  carry out of the MSB chunk.
- `out_ovf`  output  1  result not representable.

## Operation
- **States:** IDLE, RUN, DONE. `in_ready` = (state == IDLE) && !rst. `out_valid` = (state == DONE).
- **IDLE:** on `in_valid && in_ready`, capture the operand, mode and effective-negate flag `neg`; clear chunk index k to 0; go to RUN.
- **Captured operand `op`:**
  - Modes 00, 01, 10: `op = in_data`.
  - Mode 11: `op = {1'b0, in_data[N-2:0]}`.
- **Effective-negate flag `neg`:**
  - Mode 00: 0.
  - Mode 01: 1.
  - Mode 10 and mode 11: `in_data[N-1]`.
- **Carry register:** loads `neg` at accept.
- **RUN, per cycle, chunk k (bits k·W+W-1 .. k·W):**
  - Compute `(op_chunk ^ {W{neg}}) + carry`.
  - Write the W-bit sum into the result register.
  - Register the carry out; k increments.
  - After chunk N/W−1, go to DONE and latch `out_cout` from the final carry.
- **`out_cout`:** always 0 when `neg` = 0. When `neg` = 1 it is 1 only for a zero `op`.
- **`out_ovf` (wrap build):** set when `neg` = 1 in mode 01 or 10 and `in_data` = 1<<(N−1). Mode 11 never overflows; −0 yields 0 with `out_cout` = 1.
- **DONE:** `out_data`, `out_cout` and `out_ovf` hold stable while `out_ready` is low. On `out_ready` the unit goes to IDLE.
- **No overlap:** `in_ready` is low in RUN and DONE, so a new operand cannot be accepted in the same cycle as the output handshake.
- **Unused inputs:** `in_data` and `in_mode` are ignored outside the accept cycle.

## Timing
- **Reset values:** state IDLE, `out_valid` 0, `out_data` 0, `out_cout` 0, `out_ovf` 0, carry 0, k 0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` falls.
- **Latency:** accept at edge t; `out_valid` is high after edge t + N/W. For W = N this is one cycle.
- **Throughput:** one operand per N/W + 2 cycles with `out_ready` held high.
- **Reset mid-operation:** reset in RUN or DONE abandons the operation. No `out_valid` pulse appears and the partial result is cleared.
- **Wrap-around:** k wraps to 0 only via accept; it never runs past N/W−1.

## Configuration
- **`CHUNKED_NEGATOR_SAT_EN` defined:** an overflow case outputs the saturated value 0 followed by N−1 ones (0x7FFF for N = 16). `out_ovf` = 1 and `out_cout` = 0. Saturation is applied on entry to DONE with no extra cycle.
- **Not defined:** results wrap (0x8000 stays 0x8000) and `out_ovf` still flags the case.

## Test plan
- **Negate 1** (N = 16, W = 4, mode 01): `in_data` 0x0001 accepted -> exactly 4 cycles later `out_valid`, `out_data` 0xFFFF, `out_cout` 0, `out_ovf` 0. Then negate 0x0000 -> 0x0000 with `out_cout` 1.
- **Abs:** mode 10 on 0xFFF6 -> 0x000A. Mode 10 on 0x8000 -> 0x8000 with `out_ovf` 1; with `CHUNKED_NEGATOR_SAT_EN` -> 0x7FFF with `out_ovf` 1.
- **Sign-magnitude and pass:** mode 11 on 0x8005 -> 0xFFFB; mode 11 on 0x8000 -> 0x0000 with `out_cout` 1; mode 00 on 0x1234 -> 0x1234 with `out_cout` 0.
- **Backpressure:** hold `out_ready` low 10 cycles after `out_valid` -> outputs stable and `in_ready` 0 throughout. Raise `out_ready` -> IDLE next cycle with `in_ready` 1.
- **Reset mid-run:** assert `rst` 2 cycles after accept -> next cycle `out_valid` 0 and `out_data` 0. The first operand after reset completes normally.
- **Degenerate W = N = 16:** negate 0x0003 -> 0xFFFD one cycle after accept.
